src1_fwd_ctrl: RTL and testbench
================================

Name: src1_fwd_ctrl

Overview:
- Forwarding/hazard control that produces the 3-bit src1 operand-select code consumed by the EX-stage src1 operand mux.
- Tracks destination registers of the instructions in EX and MEM internally, decodes the ID-stage src1 kind, and registers the select code into EX.
- Detects load-use hazards on src1 and requests a one-cycle ID stall plus EX bubble.
- Sits between decode and the EX operand mux in the 16-bit, 16-register pipeline.

Parameters:
- REG_W, 4, register-address width.
- ZERO_REG, 1, when 1, register 0 reads as constant zero and is never forwarded or hazard-checked.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_ext  in  1  global pipeline hold (memory wait); freezes all state
- flush  in  1  taken-branch squash; ID instruction becomes a bubble in EX
- id_valid  in  1  ID holds a real instruction
- id_src1_reg  in  REG_W  src1 register address in ID
- id_src1_kind  in  2  00 reg, 01 imm4, 10 imm8, 11 pc
- id_dst  in  REG_W  destination register of ID instruction
- id_we  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load
- src1sel  out  3  EX-stage select: 000 reg, 001 imm4 sext, 010 imm8 sext, 011 pc, 100 MEM_dst, 110 EX_ALU
- load_use_stall  out  1  hold PC/IF/ID this cycle
- ex_dst, mem_dst  out  REG_W  tracked destinations (debug/bench)
- ex_we, mem_we  out  1  tracked write enables

Behaviour:
- Reset (async, rst=1): src1sel=000; ex_dst=mem_dst=0; ex_we=mem_we=0; internal ex_ld=0; load_use_stall=0.
- Pipeline tracking: EX stage = {ex_dst, ex_we, ex_ld}; MEM stage = {mem_dst, mem_we}.
- Each rising edge with stall_ext=0:
  - MEM <= EX.
  - EX <= ID, or a bubble (we=0, ld=0, src1sel=000) when flush=1, load_use_stall=1, or id_valid=0.
- stall_ext=1: every register holds, regardless of other inputs. load_use_stall is still reported combinationally.
- Match definitions:
  - src_is_reg = id_valid & (id_src1_kind==00) & !(ZERO_REG & id_src1_reg==0).
  - hit_ex = src_is_reg & ex_we & (ex_dst==id_src1_reg).
  - hit_mem = src_is_reg & mem_we & (mem_dst==id_src1_reg).
- load_use_stall = hit_ex & ex_ld & !flush. This is combinational; no other path is combinational.
- Next src1sel, registered into EX:
  - kind 01/10/11 -> 001/010/011.
  - hit_ex (non-load) -> 110, EX_ALU. The producer is one ahead when the consumer reaches EX.
  - else hit_mem -> 100, MEM_dst.
  - else 000.
  - EX priority over MEM when both match.
- Load-use sequence: cycle N, stall asserted and bubble enters EX. Cycle N+1, the load is in MEM, hit_mem fires, and src1sel registers 100. The result is exactly one bubble.
- Three-ahead producer (in WB while consumer in ID) is not tracked. Register-file write-before-read bypass covers it.
- flush together with a hazard: flush wins, no stall, bubble.
- rst asserted mid-stall: immediate return to reset values; load_use_stall drops.
- Latency: src1sel valid one clk after the instruction is in ID with stall_ext=0.

Decomposition:
- Shared package holds:
  - SRC1SEL_REG/IMM4/IMM8/PC/MEM/EXALU = 000/001/010/011/100/110.
  - SRC_KIND_REG/IMM4/IMM8/PC = 00/01/10/11.
  - REG_W.
- One natural sub-module, fwd_stage_reg: a stage register with hold and bubble-insert, instantiated for EX and MEM.
- Compare/select logic stays in the top module.

Test Plan:
- Reset mid-run: rst=1 after traffic -> next sample src1sel=000, ex_we=mem_we=0, load_use_stall=0.
- Back-to-back ALU: ADD R3 (id_we=1, dst=3), then consumer src1=R3 kind 00 -> consumer's src1sel=110. With one unrelated instruction between -> 100. Producer dst=R0 -> 000.
- Load-use: LW R5, then consumer src1=R5 -> load_use_stall=1 for exactly 1 cycle, EX bubble (ex_we=0), next src1sel=100.
- Double match: EX and MEM both write R2, consumer src1=R2 -> 110. Consumer kind 11 with matching reg -> 011 and no stall.
- flush=1 during a load-use hazard -> load_use_stall=0, EX bubble. Next instruction not stalled.
- stall_ext=1 for 3 cycles during a load-use hazard -> all outputs frozen, then release -> one bubble, src1sel=100.

Source files
------------

// File: rtl/src1_fwd_ctrl_pkg.sv
// rtl/src1_fwd_ctrl_pkg.sv - shared constants for the src1 forwarding controller
package src1_fwd_ctrl_pkg;

  // Register-address width of the 16-register file
  localparam int REG_W = 4;

  // EX-stage src1 operand-mux select codes
  localparam logic [2:0] SRC1SEL_REG   = 3'b000;
  localparam logic [2:0] SRC1SEL_IMM4  = 3'b001;
  localparam logic [2:0] SRC1SEL_IMM8  = 3'b010;
  localparam logic [2:0] SRC1SEL_PC    = 3'b011;
  localparam logic [2:0] SRC1SEL_MEM   = 3'b100;
  localparam logic [2:0] SRC1SEL_EXALU = 3'b110;

  // ID-stage src1 operand kinds
  localparam logic [1:0] SRC_KIND_REG  = 2'b00;
  localparam logic [1:0] SRC_KIND_IMM4 = 2'b01;
  localparam logic [1:0] SRC_KIND_IMM8 = 2'b10;
  localparam logic [1:0] SRC_KIND_PC   = 2'b11;

  // Select code for non-register kinds; a register kind maps to the plain
  // register-file read and is refined by the forwarding compare.
  function automatic logic [2:0] kind_to_sel(input logic [1:0] kind);
    logic [2:0] sel;
    sel = SRC1SEL_REG;
    case (kind)
      SRC_KIND_IMM4: sel = SRC1SEL_IMM4;
      SRC_KIND_IMM8: sel = SRC1SEL_IMM8;
      SRC_KIND_PC:   sel = SRC1SEL_PC;
      default:       sel = SRC1SEL_REG;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// rtl/fwd_stage_reg.sv - pipeline stage register with hold and bubble insert
module fwd_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold freezes the stage; otherwise load the next word or an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (bubble) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/src1_fwd_ctrl.sv
// rtl/src1_fwd_ctrl.sv - src1 forwarding select and load-use hazard control
module src1_fwd_ctrl #(
  parameter int REG_W    = src1_fwd_ctrl_pkg::REG_W,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ext,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1_reg,
  input  logic [1:0]       id_src1_kind,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_we,
  input  logic             id_is_load,
  output logic [2:0]       src1sel,
  output logic             load_use_stall,
  output logic [REG_W-1:0] ex_dst,
  output logic [REG_W-1:0] mem_dst,
  output logic             ex_we,
  output logic             mem_we
);

  import src1_fwd_ctrl_pkg::*;

  // EX word: {src1sel, dst, we, ld}; MEM word: {dst, we}
  localparam int EX_W  = 3 + REG_W + 2;
  localparam int MEM_W = REG_W + 1;

  logic [EX_W-1:0]  ex_d;
  logic [EX_W-1:0]  ex_q;
  logic [MEM_W-1:0] mem_d;
  logic [MEM_W-1:0] mem_q;
  logic             ex_ld;

  logic             src_is_reg;
  logic             hit_ex;
  logic             hit_mem;
  logic             ex_bubble;
  logic [2:0]       next_sel;

  // Compare the ID src1 register against the tracked EX and MEM producers
  always_comb begin
    src_is_reg = id_valid && (id_src1_kind == SRC_KIND_REG)
                 && !((ZERO_REG != 0) && (id_src1_reg == '0));
    hit_ex     = src_is_reg && ex_we  && (ex_dst  == id_src1_reg);
    hit_mem    = src_is_reg && mem_we && (mem_dst == id_src1_reg);
  end

  // A load still in EX cannot feed ID's consumer; a squash overrides the stall
  assign load_use_stall = hit_ex && ex_ld && !flush;

  // Anything that is not a real, advancing instruction enters EX as a bubble
  assign ex_bubble = flush || load_use_stall || !id_valid;

  // Select for the consumer once it reaches EX; the nearer producer wins
  always_comb begin
    next_sel = kind_to_sel(id_src1_kind);
    if (id_src1_kind == SRC_KIND_REG) begin
      if (hit_ex) begin
        next_sel = SRC1SEL_EXALU;
      end else if (hit_mem) begin
        next_sel = SRC1SEL_MEM;
      end else begin
        next_sel = SRC1SEL_REG;
      end
    end
  end

  assign ex_d  = {next_sel, id_dst, id_we, id_is_load};
  assign mem_d = {ex_dst, ex_we};

  fwd_stage_reg #(.W(EX_W)) u_ex_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_ext),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  fwd_stage_reg #(.W(MEM_W)) u_mem_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_ext),
    .bubble (1'b0),
    .d      (mem_d),
    .q      (mem_q)
  );

  assign {src1sel, ex_dst, ex_we, ex_ld} = ex_q;
  assign {mem_dst, mem_we}               = mem_q;

endmodule

// File: tb/tb_src1_fwd_ctrl.sv
// tb/tb_src1_fwd_ctrl.sv - scoreboard bench for src1_fwd_ctrl
module tb_src1_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       stall_ext;
  logic       flush;
  logic       id_valid;
  logic [3:0] id_src1_reg;
  logic [1:0] id_src1_kind;
  logic [3:0] id_dst;
  logic       id_we;
  logic       id_is_load;
  logic [2:0] src1sel;
  logic       load_use_stall;
  logic [3:0] ex_dst;
  logic [3:0] mem_dst;
  logic       ex_we;
  logic       mem_we;

  typedef struct {
    string      nm;
    logic [2:0] sel;
    logic       exwe;
    logic [3:0] exdst;
    logic       memwe;
    logic [3:0] memdst;
    logic       lus;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  src1_fwd_ctrl #(.REG_W(4), .ZERO_REG(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_ext      (stall_ext),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_src1_reg    (id_src1_reg),
    .id_src1_kind   (id_src1_kind),
    .id_dst         (id_dst),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .src1sel        (src1sel),
    .load_use_stall (load_use_stall),
    .ex_dst         (ex_dst),
    .mem_dst        (mem_dst),
    .ex_we          (ex_we),
    .mem_we         (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "src1sel",        int'(src1sel),        int'(e.sel));
        chk(e.nm, "ex_we",          int'(ex_we),          int'(e.exwe));
        chk(e.nm, "ex_dst",         int'(ex_dst),         int'(e.exdst));
        chk(e.nm, "mem_we",         int'(mem_we),         int'(e.memwe));
        chk(e.nm, "mem_dst",        int'(mem_dst),        int'(e.memdst));
        chk(e.nm, "load_use_stall", int'(load_use_stall), int'(e.lus));
      end
    end
  end

  // One cycle of ID stimulus plus the outputs expected during that same cycle:
  // registered fields reflect the previous cycle's inputs, the stall is combinational
  task automatic step(input string nm,
                      input logic r, input logic s, input logic f, input logic v,
                      input logic [3:0] sreg, input logic [1:0] kind,
                      input logic [3:0] dst, input logic we, input logic ld,
                      input logic [2:0] e_sel, input logic e_exwe, input logic [3:0] e_exdst,
                      input logic e_memwe, input logic [3:0] e_memdst, input logic e_lus);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    stall_ext    = s;
    flush        = f;
    id_valid     = v;
    id_src1_reg  = sreg;
    id_src1_kind = kind;
    id_dst       = dst;
    id_we        = we;
    id_is_load   = ld;
    e.nm     = nm;
    e.sel    = e_sel;
    e.exwe   = e_exwe;
    e.exdst  = e_exdst;
    e.memwe  = e_memwe;
    e.memdst = e_memdst;
    e.lus    = e_lus;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_ext = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_src1_reg = '0; id_src1_kind = '0; id_dst = '0; id_we = 1'b0; id_is_load = 1'b0;

    //     name         rst stl fl  v  sreg kind dst we ld    sel exwe exdst memwe memdst lus
    step("rst0",        1, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  0, 0,  0);
    step("rst1",        0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  0, 0,  0);
    // Back-to-back ALU producer R3 -> consumer gets EX_ALU
    step("alu_prod",    0, 0, 0, 1, 1, 0, 3,  1, 0,    0, 0, 0,  0, 0,  0);
    step("alu_cons",    0, 0, 0, 1, 3, 0, 4,  1, 0,    0, 1, 3,  0, 0,  0);
    step("alu_ex",      0, 0, 0, 0, 0, 0, 0,  0, 0,    6, 1, 4,  1, 3,  0);
    step("alu_drain",   0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  1, 4,  0);
    // One unrelated instruction between producer R6 and consumer -> MEM_dst
    step("gap_prod",    0, 0, 0, 1, 0, 1, 6,  1, 0,    0, 0, 0,  0, 0,  0);
    step("gap_mid",     0, 0, 0, 1, 0, 1, 7,  1, 0,    1, 1, 6,  0, 0,  0);
    step("gap_cons",    0, 0, 0, 1, 6, 0, 8,  1, 0,    1, 1, 7,  1, 6,  0);
    // Producer writes R0: consumer of R0 is never forwarded
    step("r0_prod",     0, 0, 0, 1, 0, 1, 0,  1, 0,    4, 1, 8,  1, 7,  0);
    step("r0_cons",     0, 0, 0, 1, 0, 0, 9,  1, 0,    1, 1, 0,  1, 8,  0);
    step("r0_ex",       0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 1, 9,  1, 0,  0);
    step("r0_drain",    0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  1, 9,  0);
    // Load-use on R5: one stall cycle, one bubble, then MEM_dst
    step("lu_load",     0, 0, 0, 1, 0, 1, 5,  1, 1,    0, 0, 0,  0, 0,  0);
    step("lu_cons",     0, 0, 0, 1, 5, 0, 10, 1, 0,    1, 1, 5,  0, 0,  1);
    step("lu_hold",     0, 0, 0, 1, 5, 0, 10, 1, 0,    0, 0, 0,  1, 5,  0);
    step("lu_ex",       0, 0, 0, 0, 0, 0, 0,  0, 0,    4, 1, 10, 0, 0,  0);
    step("lu_drain",    0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  1, 10, 0);
    // EX and MEM both write R2 -> EX wins; then pc-kind with a load on R2 in EX
    step("dm_a",        0, 0, 0, 1, 0, 1, 2,  1, 0,    0, 0, 0,  0, 0,  0);
    step("dm_b",        0, 0, 0, 1, 0, 1, 2,  1, 0,    1, 1, 2,  0, 0,  0);
    step("dm_cons",     0, 0, 0, 1, 2, 0, 2,  1, 1,    1, 1, 2,  1, 2,  0);
    step("pc_cons",     0, 0, 0, 1, 2, 3, 12, 1, 0,    6, 1, 2,  1, 2,  0);
    step("pc_ex",       0, 0, 0, 0, 0, 0, 0,  0, 0,    3, 1, 12, 1, 2,  0);
    step("pc_drain",    0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  1, 12, 0);
    // Flush during a load-use hazard: no stall, bubble, next one not stalled
    step("fl_load",     0, 0, 0, 1, 0, 1, 5,  1, 1,    0, 0, 0,  0, 0,  0);
    step("fl_cons",     0, 0, 1, 1, 5, 0, 13, 1, 0,    1, 1, 5,  0, 0,  0);
    step("fl_next",     0, 0, 0, 1, 5, 0, 14, 1, 0,    0, 0, 0,  1, 5,  0);
    step("fl_ex",       0, 0, 0, 0, 0, 0, 0,  0, 0,    4, 1, 14, 0, 0,  0);
    step("fl_drain",    0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  1, 14, 0);
    // External stall for 3 cycles across a load-use hazard on R7
    step("sx_load",     0, 0, 0, 1, 0, 1, 7,  1, 1,    0, 0, 0,  0, 0,  0);
    step("sx_s1",       0, 1, 0, 1, 7, 0, 15, 1, 0,    1, 1, 7,  0, 0,  1);
    step("sx_s2",       0, 1, 0, 1, 7, 0, 15, 1, 0,    1, 1, 7,  0, 0,  1);
    step("sx_s3",       0, 1, 0, 1, 7, 0, 15, 1, 0,    1, 1, 7,  0, 0,  1);
    step("sx_rel",      0, 0, 0, 1, 7, 0, 15, 1, 0,    1, 1, 7,  0, 0,  1);
    step("sx_hold",     0, 0, 0, 1, 7, 0, 15, 1, 0,    0, 0, 0,  1, 7,  0);
    step("sx_ex",       0, 0, 0, 0, 0, 0, 0,  0, 0,    4, 1, 15, 0, 0,  0);
    // Reset asserted in the middle of a stalled hazard
    step("rs_load",     0, 0, 0, 1, 0, 1, 9,  1, 1,    0, 0, 0,  1, 15, 0);
    step("rs_cons",     0, 1, 0, 1, 9, 0, 1,  1, 0,    1, 1, 9,  0, 0,  1);
    step("rs_rst",      1, 1, 0, 1, 9, 0, 1,  1, 0,    0, 0, 0,  0, 0,  0);
    step("rs_rel",      0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  0, 0,  0);
    step("rs_idle",     0, 0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0,  0, 0,  0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
